// File: rtl/soc_chip_top.sv
`timescale 1ns/1ps
// Reduced chip top: UART-to-SPI byte bridge. Each byte received on rxd is shifted
// out on SPI (mode 0, MSB first); the byte captured on spi_miso is echoed on txd.
module soc_chip_top #(
   parameter int UART_DIV  = 868,
   parameter int SPI_DIV   = 4,
   parameter int TXQ_DEPTH = 4
) (
   input  logic clk_p,
   input  logic clk_n,
   input  logic rst_top,
   input  logic rxd,
   output logic txd,
   output logic spi_cs,
   output logic spi_sclk,
   output logic spi_mosi,
   input  logic spi_miso,
   output logic sd_reset
);

   localparam int UART_CW = $clog2(UART_DIV + 1);
   localparam int SPI_CW  = $clog2(SPI_DIV + 1);
   localparam int QAW     = $clog2(TXQ_DEPTH);

   localparam logic [UART_CW-1:0] UART_ZERO = UART_CW'(0);
   localparam logic [UART_CW-1:0] UART_ONE  = UART_CW'(1);
   localparam logic [UART_CW-1:0] UART_LAST = UART_CW'(UART_DIV - 1);
   localparam logic [UART_CW-1:0] UART_HALF = UART_CW'(UART_DIV / 2 - 1);
   localparam logic [SPI_CW-1:0]  SPI_ZERO  = SPI_CW'(0);
   localparam logic [SPI_CW-1:0]  SPI_ONE   = SPI_CW'(1);
   localparam logic [SPI_CW-1:0]  SPI_LAST  = SPI_CW'(SPI_DIV - 1);
   localparam logic [QAW:0]       Q_ZERO    = (QAW + 1)'(0);
   localparam logic [QAW:0]       Q_ONE     = (QAW + 1)'(1);
   localparam logic [QAW:0]       Q_FULL    = (QAW + 1)'(TXQ_DEPTH);
   localparam logic [QAW-1:0]     QP_ZERO   = QAW'(0);
   localparam logic [QAW-1:0]     QP_ONE    = QAW'(1);

   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
   typedef enum logic [1:0] {SPI_IDLE = 2'd0, SPI_LOW = 2'd1, SPI_HIGH = 2'd2, SPI_END = 2'd3} spi_state_t;
   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;

   logic [1:0] rst_sync_r;
   logic       rst_s;
   logic       unused_s;
   logic       rxd_meta_r, rxd_sync_r;

   rx_state_t          rx_state_r, rx_state_s;
   logic [UART_CW-1:0] rx_cnt_r, rx_cnt_s;
   logic [2:0]         rx_bit_r, rx_bit_s;
   logic [7:0]         rx_sh_r, rx_sh_s;
   logic               rx_done_s;
   logic               hold_full_r;
   logic [7:0]         hold_data_r;

   spi_state_t         spi_state_r, spi_state_s;
   logic [SPI_CW-1:0]  spi_cnt_r, spi_cnt_s;
   logic [2:0]         spi_bit_r, spi_bit_s;
   logic [6:0]         spi_tx_r, spi_tx_s;
   logic [7:0]         spi_rx_r, spi_rx_s;
   logic               spi_cs_r, spi_cs_s, spi_sclk_r, spi_sclk_s, spi_mosi_r, spi_mosi_s;
   logic               spi_start_s, spi_push_s;

   logic [7:0]         q_mem_r [TXQ_DEPTH];
   logic [QAW-1:0]     q_wr_r, q_rd_r;
   logic [QAW:0]       q_cnt_r;
   logic               q_full_s, q_empty_s, q_pop_s, q_push_s;

   tx_state_t          tx_state_r, tx_state_s;
   logic [UART_CW-1:0] tx_cnt_r, tx_cnt_s;
   logic [2:0]         tx_bit_r, tx_bit_s;
   logic [7:0]         tx_sh_r, tx_sh_s;
   logic               txd_r, txd_s;

   // Reset synchronizer: asserts with rst_top, releases two edges after it falls
   always_ff @(posedge clk_p or posedge rst_top) begin
      if (rst_top) begin
         rst_sync_r <= 2'b11;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b0};
      end
   end

   assign rst_s    = rst_sync_r[1];
   assign sd_reset = rst_sync_r[1];
   assign unused_s = clk_n;

   // Double-flop the asynchronous UART input
   always_ff @(posedge clk_p or posedge rst_s) begin
      if (rst_s) begin
         rxd_meta_r <= 1'b1;
         rxd_sync_r <= 1'b1;
      end else begin
         rxd_meta_r <= rxd;
         rxd_sync_r <= rxd_meta_r;
      end
   end

   // UART RX next-state: mid-bit recheck of start, LSB-first data, stop validation
   always_comb begin
      rx_state_s = rx_state_r;
      rx_cnt_s   = rx_cnt_r;
      rx_bit_s   = rx_bit_r;
      rx_sh_s    = rx_sh_r;
      rx_done_s  = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            rx_cnt_s = UART_ZERO;
            rx_bit_s = 3'd0;
            if (!rxd_sync_r) begin
               rx_state_s = RX_START;
            end else begin
               rx_state_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_r == UART_HALF) begin
               rx_cnt_s = UART_ZERO;
               if (!rxd_sync_r) begin
                  rx_state_s = RX_DATA;
               end else begin
                  rx_state_s = RX_IDLE;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + UART_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == UART_LAST) begin
               rx_cnt_s = UART_ZERO;
               rx_sh_s  = {rxd_sync_r, rx_sh_r[7:1]};
               if (rx_bit_r == 3'd7) begin
                  rx_state_s = RX_STOP;
               end else begin
                  rx_bit_s = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + UART_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt_r == UART_LAST) begin
               rx_cnt_s   = UART_ZERO;
               rx_done_s  = rxd_sync_r;
               rx_state_s = RX_IDLE;
            end else begin
               rx_cnt_s = rx_cnt_r + UART_ONE;
            end
         end
         default: begin
            rx_state_s = RX_IDLE;
         end
      endcase
   end

   // UART RX state register
   always_ff @(posedge clk_p or posedge rst_s) begin
      if (rst_s) begin
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= UART_ZERO;
         rx_bit_r   <= 3'd0;
         rx_sh_r    <= 8'h00;
      end else begin
         rx_state_r <= rx_state_s;
         rx_cnt_r   <= rx_cnt_s;
         rx_bit_r   <= rx_bit_s;
         rx_sh_r    <= rx_sh_s;
      end
   end

   // Single-entry hold register; a byte arriving while it is full is dropped
   always_ff @(posedge clk_p or posedge rst_s) begin
      if (rst_s) begin
         hold_full_r <= 1'b0;
         hold_data_r <= 8'h00;
      end else if (spi_start_s) begin
         hold_full_r <= 1'b0;
      end else if (rx_done_s && !hold_full_r) begin
         hold_full_r <= 1'b1;
         hold_data_r <= rx_sh_r;
      end
   end

   // SPI master next-state: mode 0, MSB first, SPI_DIV cycles per sclk phase
   always_comb begin
      spi_state_s = spi_state_r;
      spi_cnt_s   = spi_cnt_r;
      spi_bit_s   = spi_bit_r;
      spi_tx_s    = spi_tx_r;
      spi_rx_s    = spi_rx_r;
      spi_cs_s    = spi_cs_r;
      spi_sclk_s  = spi_sclk_r;
      spi_mosi_s  = spi_mosi_r;
      spi_start_s = 1'b0;
      spi_push_s  = 1'b0;
      case (spi_state_r)
         SPI_IDLE: begin
            spi_cnt_s = SPI_ZERO;
            spi_bit_s = 3'd0;
            if (hold_full_r && !q_full_s) begin
               spi_start_s = 1'b1;
               spi_tx_s    = hold_data_r[6:0];
               spi_mosi_s  = hold_data_r[7];
               spi_cs_s    = 1'b0;
               spi_state_s = SPI_LOW;
            end else begin
               spi_state_s = SPI_IDLE;
            end
         end
         SPI_LOW: begin
            if (spi_cnt_r == SPI_LAST) begin
               spi_cnt_s   = SPI_ZERO;
               spi_sclk_s  = 1'b1;
               spi_rx_s    = {spi_rx_r[6:0], spi_miso};
               spi_state_s = SPI_HIGH;
            end else begin
               spi_cnt_s = spi_cnt_r + SPI_ONE;
            end
         end
         SPI_HIGH: begin
            if (spi_cnt_r == SPI_LAST) begin
               spi_cnt_s  = SPI_ZERO;
               spi_sclk_s = 1'b0;
               if (spi_bit_r == 3'd7) begin
                  spi_cs_s    = 1'b1;
                  spi_mosi_s  = 1'b0;
                  spi_push_s  = 1'b1;
                  spi_state_s = SPI_END;
               end else begin
                  spi_bit_s   = spi_bit_r + 3'd1;
                  spi_mosi_s  = spi_tx_r[6];
                  spi_tx_s    = {spi_tx_r[5:0], 1'b0};
                  spi_state_s = SPI_LOW;
               end
            end else begin
               spi_cnt_s = spi_cnt_r + SPI_ONE;
            end
         end
         SPI_END: begin
            if (spi_cnt_r == SPI_LAST) begin
               spi_cnt_s   = SPI_ZERO;
               spi_state_s = SPI_IDLE;
            end else begin
               spi_cnt_s = spi_cnt_r + SPI_ONE;
            end
         end
         default: begin
            spi_state_s = SPI_IDLE;
            spi_cs_s    = 1'b1;
            spi_sclk_s  = 1'b0;
         end
      endcase
   end

   // SPI state register and pin flops
   always_ff @(posedge clk_p or posedge rst_s) begin
      if (rst_s) begin
         spi_state_r <= SPI_IDLE;
         spi_cnt_r   <= SPI_ZERO;
         spi_bit_r   <= 3'd0;
         spi_tx_r    <= 7'h00;
         spi_rx_r    <= 8'h00;
         spi_cs_r    <= 1'b1;
         spi_sclk_r  <= 1'b0;
         spi_mosi_r  <= 1'b0;
      end else begin
         spi_state_r <= spi_state_s;
         spi_cnt_r   <= spi_cnt_s;
         spi_bit_r   <= spi_bit_s;
         spi_tx_r    <= spi_tx_s;
         spi_rx_r    <= spi_rx_s;
         spi_cs_r    <= spi_cs_s;
         spi_sclk_r  <= spi_sclk_s;
         spi_mosi_r  <= spi_mosi_s;
      end
   end

   assign q_full_s  = (q_cnt_r == Q_FULL);
   assign q_empty_s = (q_cnt_r == Q_ZERO);
   assign q_push_s  = spi_push_s & (~q_full_s | q_pop_s);

   // TX FIFO storage
   always_ff @(posedge clk_p) begin
      if (q_push_s) begin
         q_mem_r[q_wr_r] <= spi_rx_r;
      end
   end

   // TX FIFO pointers and occupancy; push and pop together leave the count alone
   always_ff @(posedge clk_p or posedge rst_s) begin
      if (rst_s) begin
         q_wr_r  <= QP_ZERO;
         q_rd_r  <= QP_ZERO;
         q_cnt_r <= Q_ZERO;
      end else begin
         if (q_push_s) begin
            q_wr_r <= q_wr_r + QP_ONE;
         end
         if (q_pop_s) begin
            q_rd_r <= q_rd_r + QP_ONE;
         end
         case ({q_push_s, q_pop_s})
            2'b10:   q_cnt_r <= q_cnt_r + Q_ONE;
            2'b01:   q_cnt_r <= q_cnt_r - Q_ONE;
            default: q_cnt_r <= q_cnt_r;
         endcase
      end
   end

   // UART TX next-state: back-to-back 8N1 frames while the FIFO has data
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r;
      tx_bit_s   = tx_bit_r;
      tx_sh_s    = tx_sh_r;
      txd_s      = txd_r;
      q_pop_s    = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            tx_cnt_s = UART_ZERO;
            txd_s    = 1'b1;
            if (!q_empty_s) begin
               q_pop_s    = 1'b1;
               tx_sh_s    = q_mem_r[q_rd_r];
               txd_s      = 1'b0;
               tx_state_s = TX_START;
            end else begin
               tx_state_s = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_cnt_r == UART_LAST) begin
               tx_cnt_s   = UART_ZERO;
               tx_bit_s   = 3'd0;
               txd_s      = tx_sh_r[0];
               tx_state_s = TX_DATA;
            end else begin
               tx_cnt_s = tx_cnt_r + UART_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt_r == UART_LAST) begin
               tx_cnt_s = UART_ZERO;
               if (tx_bit_r == 3'd7) begin
                  txd_s      = 1'b1;
                  tx_state_s = TX_STOP;
               end else begin
                  tx_bit_s = tx_bit_r + 3'd1;
                  txd_s    = tx_sh_r[1];
                  tx_sh_s  = {1'b0, tx_sh_r[7:1]};
               end
            end else begin
               tx_cnt_s = tx_cnt_r + UART_ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt_r == UART_LAST) begin
               tx_cnt_s = UART_ZERO;
               if (!q_empty_s) begin
                  q_pop_s    = 1'b1;
                  tx_sh_s    = q_mem_r[q_rd_r];
                  txd_s      = 1'b0;
                  tx_state_s = TX_START;
               end else begin
                  tx_state_s = TX_IDLE;
               end
            end else begin
               tx_cnt_s = tx_cnt_r + UART_ONE;
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
            txd_s      = 1'b1;
         end
      endcase
   end

   // UART TX state register and pin flop
   always_ff @(posedge clk_p or posedge rst_s) begin
      if (rst_s) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= UART_ZERO;
         tx_bit_r   <= 3'd0;
         tx_sh_r    <= 8'h00;
         txd_r      <= 1'b1;
      end else begin
         tx_state_r <= tx_state_s;
         tx_cnt_r   <= tx_cnt_s;
         tx_bit_r   <= tx_bit_s;
         tx_sh_r    <= tx_sh_s;
         txd_r      <= txd_s;
      end
   end

   assign txd      = txd_r;
   assign spi_cs   = spi_cs_r;
   assign spi_sclk = spi_sclk_r;
   assign spi_mosi = spi_mosi_r;

endmodule

// File: tb/tb_soc_chip_top.sv
`timescale 1ns/1ps
// Self-checking bench for soc_chip_top: table of UART bytes with SPI slave modes,
// scoreboarded txd echoes and SPI frames, plus framing, glitch and reset sequences.
module tb_soc_chip_top;

   localparam int UD = 16;
   localparam int SD = 2;

   logic clk_p = 1'b0;
   logic clk_n;
   logic rst_top, rxd, spi_miso;
   logic txd, spi_cs, spi_sclk, spi_mosi, sd_reset;
   logic [1:0] miso_mode;   // 0: loopback of mosi, 1: tied low, 2: tied high

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mosi_q[$];
   int cs_falls = 0;
   int frames = 0;
   int rises = 0;
   int low_cycles = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic [7:0] echo;
   } vec_t;
   vec_t vecs[7];

   assign clk_n = ~clk_p;
   always #5 clk_p = ~clk_p;
   assign spi_miso = (miso_mode == 2'd0) ? (spi_cs ? 1'b0 : spi_mosi) : (miso_mode == 2'd2);

   soc_chip_top #(.UART_DIV(UD), .SPI_DIV(SD), .TXQ_DEPTH(4)) dut (
      .clk_p(clk_p), .clk_n(clk_n), .rst_top(rst_top), .rxd(rxd), .txd(txd),
      .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .sd_reset(sd_reset)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (UD) @(negedge clk_p);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (UD) @(negedge clk_p);
      end
      rxd = stop;
      repeat (UD) @(negedge clk_p);
      rxd = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || mosi_q.size() != 0) && n < 3000) begin
         @(negedge clk_p);
         n++;
      end
      check({name, "_echo_pending"}, exp_q.size(), 0);
      check({name, "_spi_pending"}, mosi_q.size(), 0);
   endtask

   // UART receiver model on txd: pops the scoreboard on each decoded frame
   initial begin
      logic [7:0] frm;
      forever begin
         @(negedge clk_p);
         if (txd === 1'b0 && rst_top === 1'b0) begin
            repeat (UD / 2) @(negedge clk_p);
            if (txd === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (UD) @(negedge clk_p);
                  frm[i] = txd;
               end
               repeat (UD) @(negedge clk_p);
               check("txd_stop", txd, 1);
               frames++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL txd_unexpected: got frame 0x%0h, expected none", frm);
               end else begin
                  check("txd_echo", frm, exp_q.pop_front());
               end
            end
         end
      end
   end

   // SPI slave-side observer: mosi bits at sclk rise, pulse count and cs-low length
   initial begin
      logic prev_cs, prev_sclk;
      logic [7:0] mosi_b;
      prev_cs = 1'b1;
      prev_sclk = 1'b0;
      mosi_b = 8'h00;
      forever begin
         @(negedge clk_p);
         if (prev_cs && !spi_cs) begin
            cs_falls++;
            rises = 0;
            low_cycles = 0;
         end
         if (!spi_cs) low_cycles++;
         if (!spi_cs && spi_sclk && !prev_sclk) begin
            rises++;
            mosi_b = {mosi_b[6:0], spi_mosi};
         end
         if (!prev_cs && spi_cs && !rst_top) begin
            check("spi_cs_low_cycles", low_cycles, 16 * SD);
            check("spi_sclk_pulses", rises, 8);
            check("spi_sclk_idle_at_cs_rise", spi_sclk, 0);
            if (mosi_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spi_unexpected: got mosi byte 0x%0h, expected no transfer", mosi_b);
            end else begin
               check("spi_mosi_byte", mosi_b, mosi_q.pop_front());
            end
         end
         prev_cs = spi_cs;
         prev_sclk = spi_sclk;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected simulation end");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, c0, n;
      vecs[0] = '{8'hA5, 2'd0, 8'hA5};
      vecs[1] = '{8'h3C, 2'd1, 8'h00};
      vecs[2] = '{8'h3C, 2'd2, 8'hFF};
      vecs[3] = '{8'h5A, 2'd0, 8'h5A};
      vecs[4] = '{8'h00, 2'd2, 8'hFF};
      vecs[5] = '{8'hFF, 2'd1, 8'h00};
      vecs[6] = '{8'h81, 2'd0, 8'h81};

      rst_top = 1'b1;
      rxd = 1'b1;
      miso_mode = 2'd0;
      repeat (12) @(negedge clk_p);
      check("rst_txd", txd, 1);
      check("rst_spi_cs", spi_cs, 1);
      check("rst_spi_sclk", spi_sclk, 0);
      check("rst_spi_mosi", spi_mosi, 0);
      check("rst_sd_reset", sd_reset, 1);
      @(negedge clk_p);
      rst_top = 1'b0;
      @(negedge clk_p);
      check("sd_reset_after_1_edge", sd_reset, 1);
      @(negedge clk_p);
      check("sd_reset_after_2_edges", sd_reset, 0);

      for (int v = 0; v < 7; v++) begin
         miso_mode = vecs[v].mode;
         exp_q.push_back(vecs[v].echo);
         mosi_q.push_back(vecs[v].data);
         uart_send(vecs[v].data, 1'b1);
         wait_drain("vec");
      end

      miso_mode = 2'd0;
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back(8'(i));
         mosi_q.push_back(8'(i));
      end
      for (int i = 1; i <= 5; i++) uart_send(8'(i), 1'b1);
      wait_drain("b2b");

      f0 = frames;
      c0 = cs_falls;
      uart_send(8'h55, 1'b0);
      repeat (300) @(negedge clk_p);
      check("framing_err_no_spi", cs_falls, c0);
      check("framing_err_no_txd", frames, f0);

      rxd = 1'b0;
      repeat (UD / 4) @(negedge clk_p);
      rxd = 1'b1;
      repeat (300) @(negedge clk_p);
      check("glitch_no_spi", cs_falls, c0);
      check("glitch_no_txd", frames, f0);

      uart_send(8'hC3, 1'b1);
      n = 0;
      while (!(spi_cs === 1'b0 && rises == 4) && n < 400) begin
         @(negedge clk_p);
         n++;
      end
      check("midrst_reached_bit3", rises, 4);
      rst_top = 1'b1;
      #1;
      check("midrst_spi_cs", spi_cs, 1);
      check("midrst_txd", txd, 1);
      check("midrst_sclk", spi_sclk, 0);
      check("midrst_sd_reset", sd_reset, 1);
      repeat (3) @(negedge clk_p);
      rst_top = 1'b0;
      repeat (4) @(negedge clk_p);
      check("midrst_sd_reset_release", sd_reset, 0);
      exp_q.push_back(8'h7E);
      mosi_q.push_back(8'h7E);
      uart_send(8'h7E, 1'b1);
      wait_drain("after_rst");
      repeat (50) @(negedge clk_p);
      check("final_txd_idle", txd, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
